// File: rtl/adventure_inventory_tracker_pkg.sv
// Rooms package: room encoding, game status and item/terminal room constants.
package adventure_inventory_tracker_pkg;

  typedef enum logic [3:0] {
    R1 = 4'd0, R2 = 4'd1, R3 = 4'd2, R4 = 4'd3, R5 = 4'd4,
    R6 = 4'd5, R7 = 4'd6, R8 = 4'd7, R9 = 4'd8
  } room_states;

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    WON     = 2'b01,
    DEAD    = 2'b10
  } game_status_t;

  localparam room_states SWORD_ROOM    = R4;
  localparam room_states TREASURE_ROOM = R8;
  localparam room_states WIN_ROOM      = R6;
  localparam room_states DEATH_ROOM    = R7;

endpackage

// File: rtl/adventure_inventory_tracker_if.sv
// Room FSM <-> inventory tracker bus. master = room FSM, slave = tracker.
interface adventure_inventory_tracker_if #(parameter int MOVE_W = 8);
  import adventure_inventory_tracker_pkg::*;

  room_states         room;
  logic               sword;
  logic               treasure;
  logic               item_evt;
  logic [MOVE_W-1:0]  moves;
  game_status_t       status;

  modport master (output room, input sword, treasure, item_evt, moves, status);
  modport slave  (input room, output sword, treasure, item_evt, moves, status);
endinterface

// File: rtl/adventure_inventory_tracker_item_pickup.sv
// Per-item dwell counter: takes the item after PICKUP_CYCLES quiet cycles in its room.
module adventure_inventory_tracker_item_pickup
  import adventure_inventory_tracker_pkg::*;
#(
  parameter int         PICKUP_CYCLES = 4,
  parameter room_states ITEM_ROOM     = R4
) (
  input  logic       clk,
  input  logic       reset,
  input  room_states room,
  input  logic       change,
  input  logic       enable,
  output logic       held,
  output logic       evt
);
  localparam int            CW   = $clog2(PICKUP_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(PICKUP_CYCLES);

  logic [CW-1:0] dwell;
  logic          in_room;
  logic          pickup;

  assign in_room = (room == ITEM_ROOM);
  // A room change always wins over a pickup on the same edge.
  assign pickup  = enable && !change && in_room && !held && (dwell == FULL - 1'b1);

  // Dwell count, sticky held flag and one-cycle pickup pulse; all frozen once disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= '0;
      held  <= 1'b0;
      evt   <= 1'b0;
    end else begin
      evt <= pickup;
      if (enable) begin
        if (change)                        dwell <= '0;
        else if (in_room && dwell != FULL) dwell <= dwell + 1'b1;
        if (pickup) held <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/adventure_inventory_tracker.sv
// Inventory tracker: item pickups, move counter and game status FSM.
// Optional: define MOVE_LIMIT_EN to kill the player on the change after MAX_MOVES.
module adventure_inventory_tracker
  import adventure_inventory_tracker_pkg::*;
#(
  parameter int PICKUP_CYCLES = 4,
  parameter int MOVE_W        = 8,
  parameter int MAX_MOVES     = 20
) (
  input logic                          clk,
  input logic                          reset,
  adventure_inventory_tracker_if.slave bus
);
  room_states        prev_room;
  game_status_t      state, state_nxt;
  logic [MOVE_W-1:0] moves_q, moves_nxt;
  logic              change, playing;
  logic              sword_evt, treasure_evt;

  assign change  = (bus.room != prev_room);
  assign playing = (state == PLAYING);

  // Room history, move count and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_room <= R1;
      state     <= PLAYING;
      moves_q   <= '0;
    end else begin
      prev_room <= bus.room;
      state     <= state_nxt;
      moves_q   <= moves_nxt;
    end
  end

  // Next status and move count; terminal states hold everything.
  always_comb begin
    state_nxt = state;
    moves_nxt = moves_q;
    if (playing) begin
      if (change) begin
`ifdef MOVE_LIMIT_EN
        if (moves_q == MOVE_W'(MAX_MOVES)) state_nxt = DEAD;
        else if (moves_q != '1)            moves_nxt = moves_q + 1'b1;
`else
        if (moves_q != '1) moves_nxt = moves_q + 1'b1;
`endif
      end
      // The move limit outranks reaching the win room.
      if (state_nxt == PLAYING) begin
        if (bus.room == WIN_ROOM)        state_nxt = WON;
        else if (bus.room == DEATH_ROOM) state_nxt = DEAD;
      end
    end
  end

  adventure_inventory_tracker_item_pickup #(
    .PICKUP_CYCLES(PICKUP_CYCLES), .ITEM_ROOM(SWORD_ROOM)
  ) u_sword (
    .clk, .reset, .room(bus.room), .change, .enable(playing),
    .held(bus.sword), .evt(sword_evt)
  );

  adventure_inventory_tracker_item_pickup #(
    .PICKUP_CYCLES(PICKUP_CYCLES), .ITEM_ROOM(TREASURE_ROOM)
  ) u_treasure (
    .clk, .reset, .room(bus.room), .change, .enable(playing),
    .held(bus.treasure), .evt(treasure_evt)
  );

  assign bus.item_evt = sword_evt | treasure_evt;
  assign bus.moves    = moves_q;
  assign bus.status   = state;
endmodule

// File: tb/tb_adventure_inventory_tracker.sv
// Directed bench for adventure_inventory_tracker (PICKUP_CYCLES=4, MOVE_W=8, MAX_MOVES=20).
module tb_adventure_inventory_tracker;
  import adventure_inventory_tracker_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adventure_inventory_tracker_if #(.MOVE_W(8)) bus ();

  adventure_inventory_tracker #(
    .PICKUP_CYCLES(4), .MOVE_W(8), .MAX_MOVES(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int sw, input int tr, input int ev,
                           input int mv, input game_status_t st);
    check({tag, ".sword"},    32'(bus.sword),    32'(sw));
    check({tag, ".treasure"}, 32'(bus.treasure), 32'(tr));
    check({tag, ".item_evt"}, 32'(bus.item_evt), 32'(ev));
    check({tag, ".moves"},    32'(bus.moves),    32'(mv));
    check({tag, ".status"},   32'(bus.status),   32'(st));
  endtask

  // Present a room, take one rising edge, land 1 time unit after it.
  task automatic tick(input room_states r);
    bus.room = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.room = R1;
    #3;
    check_all("reset", 0, 0, 0, 0, PLAYING);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Idle in R1, then an out-of-range encoding counts as a plain move.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(R1);
      check("idle.item_evt", 32'(bus.item_evt), 0);
    end
    check_all("idle", 0, 0, 0, 0, PLAYING);
    tick(room_states'(4'd15));
    check_all("illegal_room", 0, 0, 0, 1, PLAYING);
    tick(R1);
    check_all("back_to_r1", 0, 0, 0, 2, PLAYING);

    // Walk to R4 and dwell: sword rises exactly 4 edges after R4 is captured.
    do_reset();
    tick(R2); tick(R3); tick(R4);
    check_all("enter_r4", 0, 0, 0, 3, PLAYING);
    for (int i = 1; i <= 4; i++) begin
      tick(R4);
      check($sformatf("dwell%0d.sword", i), 32'(bus.sword),    (i == 4) ? 1 : 0);
      check($sformatf("dwell%0d.evt", i),   32'(bus.item_evt), (i == 4) ? 1 : 0);
    end
    tick(R4);
    check_all("after_pickup", 1, 0, 0, 3, PLAYING);

    // Partial dwell discarded; second full visit picks up; later visits are silent.
    do_reset();
    tick(R2); tick(R3); tick(R4);
    tick(R4); tick(R4); tick(R4);
    tick(R3);
    check_all("early_leave", 0, 0, 0, 4, PLAYING);
    tick(R4);
    tick(R4); tick(R4); tick(R4);
    check("revisit3.sword", 32'(bus.sword), 0);
    tick(R4);
    check_all("revisit4", 1, 0, 1, 5, PLAYING);
    tick(R3); tick(R4);
    for (int i = 0; i < 6; i++) begin
      tick(R4);
      check("held_revisit.evt", 32'(bus.item_evt), 0);
    end
    check_all("held_revisit", 1, 0, 0, 7, PLAYING);

    // Treasure in R8, win in R6, frozen afterwards, async reset clears all.
    do_reset();
    tick(R2); tick(R3); tick(R4); tick(R5); tick(R6 == R6 ? R9 : R9); tick(R8);
    check_all("enter_r8", 0, 0, 0, 6, PLAYING);
    tick(R8); tick(R8); tick(R8);
    check("r8_dwell3.treasure", 32'(bus.treasure), 0);
    tick(R8);
    check_all("treasure_pick", 0, 1, 1, 6, PLAYING);
    tick(R6);
    check_all("won", 0, 1, 0, 7, WON);
    tick(R5);
    for (int i = 0; i < 6; i++) tick(R4);
    check_all("won_frozen", 0, 1, 0, 7, WON);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0, PLAYING);
    bus.room = R1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Death in R7 mid-dwell; everything frozen, dwell never completes.
    tick(R2); tick(R3); tick(R4);
    tick(R4); tick(R4);
    tick(R7);
    check_all("dead", 0, 0, 0, 4, DEAD);
    tick(R4);
    for (int i = 0; i < 6; i++) begin
      tick(R4);
      check("dead_dwell.evt", 32'(bus.item_evt), 0);
    end
    tick(R3); tick(R2);
    check_all("dead_frozen", 0, 0, 0, 4, DEAD);

    // Move budget (MAX_MOVES=20) versus free counting and saturation.
    do_reset();
    for (int i = 1; i <= 20; i++) tick((i % 2) ? R2 : R1);
    check_all("moves20", 0, 0, 0, 20, PLAYING);
    tick(R2);
`ifdef MOVE_LIMIT_EN
    check_all("limit_hit", 0, 0, 0, 20, DEAD);
`else
    check_all("no_limit", 0, 0, 0, 21, PLAYING);
    for (int i = 22; i <= 261; i++) tick((i % 2) ? R2 : R1);
    check_all("saturate", 0, 0, 0, 255, PLAYING);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/adventure_inventory_tracker.md
Name: adventure_inventory_tracker

Overview:
- Consumer side of the adventure-game room interface. It samples the room-state output of the room FSM and produces the sword and treasure inputs that the room FSM consumes.
- Items are picked up by dwelling in the item room for PICKUP_CYCLES clock cycles.
- Also counts moves and tracks game status: playing, won or dead.
- Sits beside the room FSM in the game top level, closing the sword/treasure feedback loop.

Parameters:
- PICKUP_CYCLES, 4: consecutive cycles the player must remain in an item room before the item is taken. Legal range is 1 or more.
- MOVE_W, 8: width of the move counter.
- MAX_MOVES, 20: move budget. Used only when MOVE_LIMIT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- room  in  room_states  current room from the room FSM, from the rooms package.
- sword  out  1  sword held (registered).
- treasure  out  1  treasure held (registered).
- item_evt  out  1  one-cycle pulse on any item pickup (registered).
- moves  out  MOVE_W  count of room changes, saturating (registered).
- status  out  game_status_t  PLAYING/WON/DEAD (registered).

Behaviour:
- Reset is asynchronous. Values while reset is high:
  - prev_room is R1.
  - Dwell counters are 0.
  - sword, treasure and item_evt are 0.
  - moves is 0.
  - status is PLAYING.
  - Reset asserted mid-game clears everything immediately, including held items and a terminal status.
- Room change: at each rising edge, a change is detected when room != prev_room. prev_room <= room every cycle.
- On a change, while status is PLAYING:
  - moves increments, saturating at 2^MOVE_W-1.
  - Both dwell counters clear to 0.
  - No pickup can occur on that edge; a change beats a pickup.
- No change: the dwell counter of the item whose room equals room increments, saturating at PICKUP_CYCLES.
- Item rooms: SWORD_ROOM=R4, TREASURE_ROOM=R8.
- Pickup:
  - Occurs on the edge where the dwell counter reaches PICKUP_CYCLES, the item is not yet held, and status is PLAYING.
  - The item flag is set at that edge and item_evt=1 for exactly that one cycle.
  - Latency: the flag rises PICKUP_CYCLES edges after the edge at which prev_room first captured the item room.
  - Leaving the room early discards the partial dwell.
- Items are sticky until reset. Re-entering an item room with the item already held produces no item_evt.
- Status FSM:
  - PLAYING -> WON when sampled room==WIN_ROOM (R6).
  - PLAYING -> DEAD when sampled room==DEATH_ROOM (R7).
  - The transition is registered at that edge.
  - WON and DEAD are terminal until reset. In either state, moves, sword, treasure and the dwell counters freeze, and item_evt stays 0.
  - The move that enters R6/R7 is counted (same edge).
- The room input is assumed legal. Any encoding outside R1..R9 is treated as a non-item, non-terminal room: it is counted as a change, but no pickup and no status change.

Optional Feature:
- MOVE_LIMIT_EN defined:
  - A room change detected while status is PLAYING and moves==MAX_MOVES drives status to DEAD at that edge.
  - This applies regardless of destination; it takes precedence over WON.
  - moves is not incremented past MAX_MOVES.
- MOVE_LIMIT_EN undefined: no move budget; moves only saturates at 2^MOVE_W-1, and MAX_MOVES is unused.

Decomposition:
- Add to the rooms package:
  - game_status_t enum: PLAYING=2'b00, WON=2'b01, DEAD=2'b10.
  - Constants SWORD_ROOM, TREASURE_ROOM, WIN_ROOM, DEATH_ROOM of type room_states.
- Sub-module item_pickup, instantiated twice (sword, treasure):
  - Parameters PICKUP_CYCLES and ITEM_ROOM.
  - Inputs: clk, reset, room, change, enable.
  - Outputs: held, evt.
- The top level ORs the two evt outputs into item_evt and owns the move counter and the status FSM.

Test Plan:
- Reset, room=R1 held 10 cycles -> status=PLAYING, moves=0, sword=0, treasure=0, item_evt never 1.
- Room sequence R1,R2,R3,R4 one per cycle, then hold R4 (PICKUP_CYCLES=4) -> moves=3; sword rises exactly 4 edges after R4 is captured; item_evt high exactly 1 cycle.
- Hold R4 for 3 cycles, go to R3, return to R4 and hold 4 cycles -> sword=0 after the first visit, sword=1 on the second visit. Further R4 visits -> no item_evt.
- Reach R8 and dwell 4 cycles, then walk to R6 -> treasure=1 then status=WON. Subsequent room changes leave moves and items unchanged. Assert reset -> all outputs return to reset values asynchronously.
- From PLAYING, room=R7 -> status=DEAD at the next edge. Toggling room afterwards -> moves frozen. A pickup dwell already in progress never completes.
- MOVE_LIMIT_EN, MAX_MOVES=3, 4 room changes -> status=DEAD on the 4th change edge, moves=3. Same stimulus without the macro -> moves=4, status=PLAYING.
